// File: rtl/tb_crc_attach_if.sv
// Byte-stream ingress handshake into tb_crc_attach.
interface tb_crc_attach_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sop;
  logic       in_eop;
  logic       in_ready;

  modport master (
    output in_valid, in_data, in_sop, in_eop,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop,
    output in_ready
  );
endinterface

// File: rtl/tb_crc_attach.sv
// TB ingress: payload to data FIFO, optional CRC24A, size word to size FIFO.
// Optional CRC append is enabled by defining TB_CRC_ATTACH_EN.
module tb_crc_attach #(
  parameter logic [23:0] CRC_POLY     = 24'h864CFB,
  parameter int          MAX_TB_BYTES = 1659
) (
  input  logic        clk,
  input  logic        reset_n,
  tb_crc_attach_if.slave s_in,
  input  logic        full_data_fifo,
  output logic        wreq_data_fifo,
  output logic [7:0]  data_fifo_d,
  input  logic        full_size_fifo,
  output logic        wreq_size_fifo,
  output logic [19:0] size_d,
  output logic        err_oversize
);

`ifdef TB_CRC_ATTACH_EN
  localparam int LIMIT = MAX_TB_BYTES - 3;
  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_CRC, S_CALC, S_WRSIZE
  } state_t;
  localparam state_t S_TAIL = S_CRC;
`else
  localparam int LIMIT = MAX_TB_BYTES;
  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_CALC, S_WRSIZE
  } state_t;
  localparam state_t S_TAIL = S_CALC;
`endif
  localparam logic [10:0] LIM = 11'(LIMIT);

  state_t      state_q;
  logic [10:0] b_q;
  logic        ovf_q;
  logic        wreq_q;
  logic [7:0]  data_q;
  logic [19:0] size_q;
  logic        err_q;
`ifdef TB_CRC_ATTACH_EN
  logic [23:0] crc_q;
  logic [1:0]  idx_q;

  function automatic logic [23:0] crc_byte(
    input logic [23:0] c,
    input logic [7:0]  d
  );
    logic [23:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[23] ^ d[i]) r = {r[22:0], 1'b0} ^ CRC_POLY;
      else              r = {r[22:0], 1'b0};
    end
    return r;
  endfunction
`else
  logic unused_poly;
  assign unused_poly = ^CRC_POLY;
`endif

  logic rdy;
  logic acc;
  assign rdy = ((state_q == S_IDLE) || (state_q == S_DATA))
             && !full_data_fifo;
  assign acc = s_in.in_valid && rdy;
  assign s_in.in_ready = rdy;

  assign wreq_data_fifo = wreq_q;
  assign data_fifo_d    = data_q;
  assign wreq_size_fifo = (state_q == S_WRSIZE) && !full_size_fifo;
  assign size_d         = size_q;
  assign err_oversize   = err_q;

  // Smallest K+/K- combination whose capacity holds B bytes.
  logic [15:0] b16;
  logic [19:0] size_c;
  assign b16 = {5'd0, b_q};

  always_comb begin
    size_c = 20'd0;
    unique case (1'b1)
      (b16 <= 16'd132):
        size_c = {2'd0, 2'd1, 16'd132 - b16};
      (b16 > 16'd132 && b16 <= 16'd768):
        size_c = {2'd1, 2'd0, 16'd768 - b16};
      (b16 > 16'd768 && b16 <= 16'd894):
        size_c = {2'd1, 2'd1, 16'd894 - b16};
      (b16 > 16'd894 && b16 <= 16'd1530):
        size_c = {2'd2, 2'd0, 16'd1530 - b16};
      default:
        size_c = {2'd2, 2'd1, 16'd1659 - b16};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      ovf_q   <= 1'b0;
      wreq_q  <= 1'b0;
      data_q  <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
`ifdef TB_CRC_ATTACH_EN
      crc_q   <= '0;
      idx_q   <= '0;
`endif
    end else begin
      wreq_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          b_q   <= '0;
          ovf_q <= 1'b0;
`ifdef TB_CRC_ATTACH_EN
          crc_q <= '0;
          idx_q <= '0;
`endif
          if (acc && s_in.in_sop) begin
            wreq_q  <= 1'b1;
            data_q  <= s_in.in_data;
            b_q     <= 11'd1;
`ifdef TB_CRC_ATTACH_EN
            crc_q   <= crc_byte(24'd0, s_in.in_data);
`endif
            state_q <= s_in.in_eop ? S_TAIL : S_DATA;
          end
        end
        S_DATA: begin
          if (acc) begin
            if (b_q < LIM) begin
              wreq_q <= 1'b1;
              data_q <= s_in.in_data;
              b_q    <= b_q + 11'd1;
`ifdef TB_CRC_ATTACH_EN
              crc_q  <= crc_byte(crc_q, s_in.in_data);
`endif
            end else if (!ovf_q) begin
              err_q <= 1'b1;
              ovf_q <= 1'b1;
            end
            if (s_in.in_eop) state_q <= S_TAIL;
          end
        end
`ifdef TB_CRC_ATTACH_EN
        // CRC shifts out MSB byte first.
        S_CRC: begin
          if (!full_data_fifo) begin
            wreq_q <= 1'b1;
            data_q <= crc_q[23:16];
            crc_q  <= {crc_q[15:0], 8'h00};
            b_q    <= b_q + 11'd1;
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd2) state_q <= S_CALC;
          end
        end
`endif
        S_CALC: begin
          size_q  <= size_c;
          state_q <= S_WRSIZE;
        end
        S_WRSIZE: begin
          if (!full_size_fifo) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
